// File: rtl/tx_char_sched.sv
// Transmit character scheduler: arbitrates time-codes, FCTs, N-chars and NULL fill
// into the DS encoder one character per valid/ready handshake, and tracks far-end credit.
module tx_char_sched #(
   parameter int unsigned CREDIT_MAX  = 56,
   parameter int unsigned CREDIT_STEP = 8
) (
   input  logic       TxClk,
   input  logic       TxReset,
   input  logic       en_null_i,
   input  logic       en_fct_i,
   input  logic       en_nchar_i,
   input  logic       tick_i,
   input  logic [7:0] time_i,
   input  logic       fct_req_i,
   input  logic       fct_rx_i,
   input  logic       fifo_valid_i,
   input  logic [8:0] fifo_dat_i,
   output logic       fifo_pop_o,
   output logic       valid_o,
   output logic [7:0] dat_o,
   output logic       lchar_o,
   input  logic       ready_i,
   output logic [5:0] credit_o,
   output logic       credit_err_o
);

   localparam logic [1:0] CodeFct = 2'b00;
   localparam logic [1:0] CodeEsc = 2'b11;
   localparam logic [5:0] CreditStep = 6'(CREDIT_STEP);

   typedef enum logic [1:0] {StIdle, StIssue, StSeqWait, StSeqIssue} state_e;
   typedef enum logic [1:0] {SelTime, SelFct, SelNchar, SelNull} sel_e;

   state_e     state_q, state_d;
   sel_e       sel_q, sel_d;
   logic [7:0] dat_q, dat_d;
   logic       lchar_q, lchar_d;
   logic [7:0] seq_dat_q, seq_dat_d;
   logic       seq_lchar_q, seq_lchar_d;
   logic       tc_pend_q, tc_pend_d;
   logic [7:0] tc_val_q, tc_val_d;
   logic [2:0] fct_pend_q, fct_pend_d;
   logic [5:0] credit_q, credit_d;
   logic       credit_err_q, credit_err_d;

   logic       elig_tc, elig_fct, elig_nchar, elig_null;
   logic       issue_tc, issue_fct, issue_nchar;
   logic [6:0] credit_sum;
   logic       credit_ovf;

   assign elig_tc    = tc_pend_q && en_nchar_i;
   assign elig_fct   = (fct_pend_q != 3'd0) && en_fct_i;
   assign elig_nchar = fifo_valid_i && en_nchar_i && (credit_q != 6'd0);
   assign elig_null  = en_null_i;

   assign issue_tc    = (state_q == StIssue) && (sel_q == SelTime);
   assign issue_fct   = (state_q == StIssue) && (sel_q == SelFct);
   assign issue_nchar = (state_q == StIssue) && (sel_q == SelNchar);

   // Character FSM; second character of ESC sequences is latched at the ESC issue edge.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      dat_d       = dat_q;
      lchar_d     = lchar_q;
      seq_dat_d   = seq_dat_q;
      seq_lchar_d = seq_lchar_q;
      case (state_q)
         StIdle: begin
            if (ready_i && (elig_tc || elig_fct || elig_nchar || elig_null)) begin
               state_d = StIssue;
               lchar_d = 1'b1;
               if (elig_tc) begin
                  sel_d = SelTime;
                  dat_d = {6'd0, CodeEsc};
               end else if (elig_fct) begin
                  sel_d = SelFct;
                  dat_d = {6'd0, CodeFct};
               end else if (elig_nchar) begin
                  sel_d   = SelNchar;
                  lchar_d = fifo_dat_i[8];
                  dat_d   = fifo_dat_i[8] ? {6'd0, fifo_dat_i[1:0]} : fifo_dat_i[7:0];
               end else begin
                  sel_d = SelNull;
                  dat_d = {6'd0, CodeEsc};
               end
            end
         end
         StIssue: begin
            if ((sel_q == SelTime) || (sel_q == SelNull)) begin
               state_d = StSeqWait;
            end else begin
               state_d = StIdle;
            end
            seq_dat_d   = (sel_q == SelTime) ? tc_val_q : {6'd0, CodeFct};
            seq_lchar_d = (sel_q != SelTime);
         end
         StSeqWait: begin
            if (ready_i) begin
               state_d = StSeqIssue;
               dat_d   = seq_dat_q;
               lchar_d = seq_lchar_q;
            end
         end
         StSeqIssue: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // A tick coinciding with the ESC issue re-arms the flag for the next time-code.
   always_comb begin
      tc_pend_d = tc_pend_q;
      tc_val_d  = tc_val_q;
      if (issue_tc) begin
         tc_pend_d = 1'b0;
      end
      if (tick_i) begin
         tc_pend_d = 1'b1;
         tc_val_d  = time_i;
      end
   end

   always_comb begin
      fct_pend_d = fct_pend_q;
      case ({fct_req_i, issue_fct})
         2'b10:   fct_pend_d = (fct_pend_q == 3'd7) ? 3'd7 : fct_pend_q + 3'd1;
         2'b01:   fct_pend_d = fct_pend_q - 3'd1;
         default: fct_pend_d = fct_pend_q;
      endcase
   end

   assign credit_sum = {1'b0, credit_q} + 7'(CREDIT_STEP);
   assign credit_ovf = credit_sum > 7'(CREDIT_MAX);

   // An overflowing FCT is flagged and dropped; a same-cycle decrement still applies.
   always_comb begin
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      if (fct_rx_i) begin
         if (credit_ovf) begin
            credit_err_d = 1'b1;
         end else begin
            credit_d = credit_q + CreditStep;
         end
      end
      if (issue_nchar) begin
         credit_d = credit_d - 6'd1;
      end
   end

   always_ff @(posedge TxClk or posedge TxReset) begin
      if (TxReset) begin
         state_q      <= StIdle;
         sel_q        <= SelNull;
         dat_q        <= 8'd0;
         lchar_q      <= 1'b0;
         seq_dat_q    <= 8'd0;
         seq_lchar_q  <= 1'b0;
         tc_pend_q    <= 1'b0;
         tc_val_q     <= 8'd0;
         fct_pend_q   <= 3'd0;
         credit_q     <= 6'd0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         dat_q        <= dat_d;
         lchar_q      <= lchar_d;
         seq_dat_q    <= seq_dat_d;
         seq_lchar_q  <= seq_lchar_d;
         tc_pend_q    <= tc_pend_d;
         tc_val_q     <= tc_val_d;
         fct_pend_q   <= fct_pend_d;
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign valid_o      = (state_q == StIssue) || (state_q == StSeqIssue);
   assign dat_o        = dat_q;
   assign lchar_o      = lchar_q;
   assign fifo_pop_o   = issue_nchar;
   assign credit_o     = credit_q;
   assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_tx_char_sched.sv
// Bench for tx_char_sched: encoder/FIFO models, a priority vector table and
// hand-written sequences for reset, credit gating, time-code atomicity and overflow.
module tb_tx_char_sched;

   localparam int EncBusy = 3;
   localparam logic [9:0] Esc = 10'h103;
   localparam logic [9:0] Fct = 10'h100;
   localparam int NV = 11;

   logic       TxClk = 1'b0;
   logic       TxReset;
   logic       en_null_i, en_fct_i, en_nchar_i, tick_i, fct_req_i, fct_rx_i;
   logic [7:0] time_i;
   logic       fifo_valid_i;
   logic [8:0] fifo_dat_i;
   logic       fifo_pop_o, valid_o, lchar_o, ready_i, credit_err_o;
   logic [7:0] dat_o;
   logic [5:0] credit_o;

   logic       enc_auto = 1'b0;
   logic       ready_man = 1'b0;
   logic       flush = 1'b0;
   logic       prev_valid = 1'b0;
   int         busy = 0;
   int         cap_n = 0;
   int         consec_n = 0;
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic [9:0] stream [1024];
   logic [8:0] fifo_mem [64];
   int         n_cmp = 0;
   int         n_fail = 0;

   typedef struct {
      logic       en_null;
      logic       en_fct;
      logic       en_nchar;
      logic       tick;
      logic [7:0] tval;
      logic       fct_req;
      logic       fct_rx;
      logic       fifo;
      logic [8:0] fdat;
      int         n_exp;
      logic [9:0] exp0;
      logic [9:0] exp1;
   } vec_t;
   vec_t vecs[NV];

   tx_char_sched dut (
      .TxClk        (TxClk),
      .TxReset      (TxReset),
      .en_null_i    (en_null_i),
      .en_fct_i     (en_fct_i),
      .en_nchar_i   (en_nchar_i),
      .tick_i       (tick_i),
      .time_i       (time_i),
      .fct_req_i    (fct_req_i),
      .fct_rx_i     (fct_rx_i),
      .fifo_valid_i (fifo_valid_i),
      .fifo_dat_i   (fifo_dat_i),
      .fifo_pop_o   (fifo_pop_o),
      .valid_o      (valid_o),
      .dat_o        (dat_o),
      .lchar_o      (lchar_o),
      .ready_i      (ready_i),
      .credit_o     (credit_o),
      .credit_err_o (credit_err_o)
   );

   always #5 TxClk = ~TxClk;

   // Encoder model: ready masked while valid, busy for a few cycles after each accept.
   assign ready_i      = (enc_auto ? (busy == 0) : ready_man) && !valid_o;
   assign fifo_valid_i = (wr_ptr != rd_ptr);
   assign fifo_dat_i   = fifo_mem[rd_ptr[5:0]];

   always @(negedge TxClk) begin
      if (flush) begin
         rd_ptr = wr_ptr;
         busy   = 0;
      end else if (valid_o) begin
         stream[cap_n[9:0]] = {fifo_pop_o, lchar_o, dat_o};
         cap_n = cap_n + 1;
         if (prev_valid) consec_n = consec_n + 1;
         if (fifo_pop_o) rd_ptr = rd_ptr + 1;
         busy = EncBusy;
      end else if (busy != 0) begin
         busy = busy - 1;
      end
      prev_valid = valid_o;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] ent(input int idx);
      if (idx < cap_n) return stream[idx[9:0]];
      return 10'h3FF;
   endfunction

   task automatic do_reset();
      TxReset = 1'b1;
      flush = 1'b1;
      enc_auto = 1'b0;
      ready_man = 1'b0;
      {en_null_i, en_fct_i, en_nchar_i, tick_i, fct_req_i, fct_rx_i} = 6'd0;
      time_i = 8'd0;
      repeat (2) @(posedge TxClk);
      #1;
      TxReset = 1'b0;
      flush = 1'b0;
   endtask

   task automatic pulse_rx();
      fct_rx_i = 1'b1;
      @(posedge TxClk);
      #1 fct_rx_i = 1'b0;
   endtask

   task automatic pulse_req();
      fct_req_i = 1'b1;
      @(posedge TxClk);
      #1 fct_req_i = 1'b0;
   endtask

   task automatic pulse_tick(input logic [7:0] v);
      time_i = v;
      tick_i = 1'b1;
      @(posedge TxClk);
      #1 tick_i = 1'b0;
   endtask

   task automatic push(input logic [8:0] d);
      fifo_mem[wr_ptr[5:0]] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_chars(input int base, input int n, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (cap_n - base >= n) break;
         @(posedge TxClk);
      end
      #1;
   endtask

   initial begin
      int base, base2, r0, ndata, last, order_err, pair_err, found;
      logic [9:0] e;

      // {null, fct, nchar, tick, tval, fct_req, fct_rx, fifo, fdat, n, exp0, exp1}
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 2, Esc, Fct};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'h000, 1, Fct, 10'h0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 9'h033, 2, Esc, 10'h0A5};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 9'h000, 1, Fct, 10'h0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 9'h0C3, 1, 10'h2C3, 10'h0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 9'h101, 1, 10'h301, 10'h0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 9'h1FE, 1, 10'h302, 10'h0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h044, 2, Esc, Fct};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 9'h081, 1, 10'h281, 10'h0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 9'h011, 0, 10'h0, 10'h0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 9'h022, 2, Esc, Fct};

      TxReset = 1'b1;
      {en_null_i, en_fct_i, en_nchar_i, tick_i, fct_req_i, fct_rx_i} = 6'd0;
      time_i = 8'd0;
      @(posedge TxClk);
      #1;
      check("reset_valid", valid_o, 0);
      check("reset_dat", dat_o, 0);
      check("reset_lchar", lchar_o, 0);
      check("reset_pop", fifo_pop_o, 0);
      check("reset_credit", credit_o, 0);
      check("reset_err", credit_err_o, 0);

      for (int v = 0; v < NV; v++) begin
         do_reset();
         if (vecs[v].fct_rx) pulse_rx();
         if (vecs[v].fct_req) pulse_req();
         if (vecs[v].tick) pulse_tick(vecs[v].tval);
         if (vecs[v].fifo) push(vecs[v].fdat);
         en_null_i  = vecs[v].en_null;
         en_fct_i   = vecs[v].en_fct;
         en_nchar_i = vecs[v].en_nchar;
         base = cap_n;
         enc_auto = 1'b1;
         if (vecs[v].n_exp == 0) begin
            repeat (30) @(posedge TxClk);
            #1;
            check($sformatf("vec%0d_silent", v), cap_n - base, 0);
         end else begin
            wait_chars(base, vecs[v].n_exp, 40);
            check($sformatf("vec%0d_char0", v), ent(base), vecs[v].exp0);
            if (vecs[v].n_exp > 1) check($sformatf("vec%0d_char1", v), ent(base + 1), vecs[v].exp1);
         end
      end

      // NULL stream, then asynchronous reset in the middle of a NULL
      do_reset();
      pulse_rx();
      check("pre_rst_credit", credit_o, 8);
      en_null_i = 1'b1;
      base = cap_n;
      enc_auto = 1'b1;
      wait_chars(base, 6, 80);
      for (int k = 0; k < 6; k++) check($sformatf("null_stream%0d", k), ent(base + k), (k % 2 == 0) ? Esc : Fct);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge TxClk);
         if (valid_o && dat_o == 8'h03) begin
            found = 1;
            break;
         end
      end
      check("rst_mid_found_esc", found, 1);
      #2 TxReset = 1'b1;
      #1;
      check("rst_async_valid", valid_o, 0);
      check("rst_async_dat", dat_o, 0);
      check("rst_async_lchar", lchar_o, 0);
      check("rst_async_credit", credit_o, 0);
      check("rst_async_pop", fifo_pop_o, 0);
      @(posedge TxClk);
      #1 TxReset = 1'b0;
      base = cap_n;
      wait_chars(base, 2, 40);
      check("rst_resume_esc", ent(base), Esc);
      check("rst_resume_fct", ent(base + 1), Fct);

      // Three FCTs ahead of an N-char, plus one-cycle selection latency
      do_reset();
      en_fct_i = 1'b1;
      en_nchar_i = 1'b1;
      pulse_rx();
      push(9'h05A);
      pulse_req();
      pulse_req();
      pulse_req();
      r0 = rd_ptr;
      base = cap_n;
      ready_man = 1'b1;
      @(negedge TxClk);
      check("latency_idle", valid_o, 0);
      @(negedge TxClk);
      check("latency_valid", valid_o, 1);
      ready_man = 1'b0;
      enc_auto = 1'b1;
      wait_chars(base, 4, 80);
      check("fct_first0", ent(base), Fct);
      check("fct_first1", ent(base + 1), Fct);
      check("fct_first2", ent(base + 2), Fct);
      check("nchar_after_fct", ent(base + 3), 10'h25A);
      repeat (20) @(posedge TxClk);
      #1;
      check("fct_stream_len", cap_n - base, 4);
      check("fct_pop_once", rd_ptr - r0, 1);
      check("fct_credit", credit_o, 7);

      // Credit gating
      do_reset();
      en_null_i = 1'b1;
      en_nchar_i = 1'b1;
      for (int k = 0; k < 10; k++) push(9'(16 + k));
      base = cap_n;
      enc_auto = 1'b1;
      repeat (40) @(posedge TxClk);
      #1;
      ndata = 0;
      for (int k = base; k < cap_n; k++) begin
         e = ent(k);
         if (e[9]) ndata++;
      end
      check("gate_no_data", ndata, 0);
      check("gate_nulls_sent", (cap_n - base) >= 4, 1);
      base2 = cap_n;
      pulse_rx();
      repeat (150) @(posedge TxClk);
      #1;
      ndata = 0;
      last = base2;
      order_err = 0;
      pair_err = 0;
      for (int k = base; k < cap_n; k++) begin
         e = ent(k);
         if (e[9]) begin
            if (e[7:0] != 8'(16 + ndata)) order_err++;
            ndata++;
            last = k;
         end
         if (e == Esc && k + 1 < cap_n && ent(k + 1) != Fct) pair_err++;
      end
      check("gate_data_count", ndata, 8);
      check("gate_data_order", order_err, 0);
      check("gate_esc_pairs", pair_err, 0);
      check("gate_nulls_resume", (cap_n - last) >= 3, 1);
      check("gate_credit_zero", credit_o, 0);
      check("gate_fifo_left", wr_ptr - rd_ptr, 2);

      // Time-code atomicity, overwrite before issue, and re-arm on the ESC issue cycle
      do_reset();
      en_fct_i = 1'b1;
      en_nchar_i = 1'b1;
      pulse_req();
      pulse_tick(8'h11);
      pulse_tick(8'h2C);
      base = cap_n;
      enc_auto = 1'b1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge TxClk);
         if (valid_o) begin
            found = 1;
            break;
         end
      end
      check("tc_esc_seen", found, 1);
      time_i = 8'h77;
      tick_i = 1'b1;
      @(posedge TxClk);
      #1 tick_i = 1'b0;
      wait_chars(base, 5, 80);
      check("tc_esc", ent(base), Esc);
      check("tc_value", ent(base + 1), 10'h02C);
      check("tc_rearm_esc", ent(base + 2), Esc);
      check("tc_rearm_value", ent(base + 3), 10'h077);
      check("tc_then_fct", ent(base + 4), Fct);
      repeat (20) @(posedge TxClk);
      #1;
      check("tc_stream_len", cap_n - base, 5);

      // Credit ceiling and overflow
      do_reset();
      for (int k = 0; k < 7; k++) pulse_rx();
      check("ovf_credit_max", credit_o, 56);
      check("ovf_no_err_yet", credit_err_o, 0);
      pulse_rx();
      check("ovf_err_set", credit_err_o, 1);
      check("ovf_credit_held", credit_o, 56);
      repeat (3) @(posedge TxClk);
      #1;
      check("ovf_err_sticky", credit_err_o, 1);
      do_reset();
      check("ovf_err_cleared", credit_err_o, 0);

      // FCT received in the same cycle as an N-char issue at credit 10
      pulse_rx();
      pulse_rx();
      for (int k = 0; k < 6; k++) push(9'(32 + k));
      r0 = rd_ptr;
      en_nchar_i = 1'b1;
      enc_auto = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if (rd_ptr - r0 >= 6) break;
         @(posedge TxClk);
      end
      repeat (6) @(posedge TxClk);
      #1;
      check("coinc_credit10", credit_o, 10);
      enc_auto = 1'b0;
      ready_man = 1'b0;
      push(9'h0AB);
      ready_man = 1'b1;
      @(posedge TxClk);
      #1;
      check("coinc_issue", valid_o, 1);
      fct_rx_i = 1'b1;
      ready_man = 1'b0;
      @(posedge TxClk);
      #1 fct_rx_i = 1'b0;
      check("coinc_credit17", credit_o, 17);
      check("coinc_pops", rd_ptr - r0, 7);

      check("no_back_to_back_valid", consec_n, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_char_sched.md
# tx_char_sched

Transmit character scheduler for the data-strobe link transmitter. It arbitrates between four sources of outgoing characters: time-codes, flow-control tokens (FCT), N-chars from the transmit FIFO, and NULL fill. It feeds the winner, one character at a time, into the DS character encoder through that encoder's valid/ready handshake. It also keeps the far-end credit count that gates N-chars, and keeps two-character sequences (ESC+FCT, ESC+time) atomic.

## Interface
Parameters:
- CREDIT_MAX, 56, credit ceiling; an FCT received above this is a credit error.
- CREDIT_STEP, 8, credit added per received FCT.

Ports:
- TxClk  in  1  transmit clock; all logic is on the rising edge.
- TxReset  in  1  asynchronous, active-high reset.
- en_null_i  in  1  NULL fill permitted (link FSM).
- en_fct_i  in  1  FCT transmission permitted.
- en_nchar_i  in  1  N-chars and time-codes permitted (Run state).
- tick_i  in  1  time-code request pulse.
- time_i  in  8  time-code value, sampled when tick_i=1.
- fct_req_i  in  1  pulse: receiver freed 8 buffer slots, so one FCT must be sent.
- fct_rx_i  in  1  pulse: an FCT was received from the far end.
- fifo_valid_i  in  1  TX FIFO not empty (show-ahead).
- fifo_dat_i  in  9  head entry. bit8=1 means control, and [1:0] holds the EOP/EEP code. bit8=0 means data in [7:0].
- fifo_pop_o  out  1  one-cycle pulse that consumes the head entry.
- valid_o  out  1  character valid to the encoder.
- dat_o  out  8  character: data byte, or control code in [1:0] with [7:2]=0.
- lchar_o  out  1  1 means control character (2-bit code).
- ready_i  in  1  encoder ready. It is combinationally masked low while valid_o=1.
- credit_o  out  6  current N-char credit.
- credit_err_o  out  1  sticky credit-overflow flag.

## Operation
- Control codes on dat_o[1:0]: FCT=00, EOP=01, EEP=10, ESC=11.
- FSM states:
  - IDLE: selection takes place here.
  - ISSUE: valid_o=1 for exactly one cycle; the encoder accepts on that edge.
  - SEQ_WAIT: waits for ready_i=1.
  - SEQ_ISSUE: valid_o=1 for one cycle, carrying the second character of a sequence.
- IDLE: if ready_i=1 and a source is eligible, register dat_o/lchar_o and go to ISSUE. Otherwise stay in IDLE with valid_o=0.
- Priority, evaluated in IDLE only:
  1. Time-code: pending and en_nchar_i. Sends ESC, then the data char time_pend.
  2. FCT: fct_pend>0 and en_fct_i. Sends one lchar 00.
  3. N-char: fifo_valid_i, en_nchar_i and credit>0. Sends the FIFO head.
  4. NULL: en_null_i. Sends ESC, then FCT.
- ISSUE goes to SEQ_WAIT if the selection was a time-code or NULL; otherwise it goes to IDLE.
- SEQ_WAIT goes to SEQ_ISSUE when ready_i=1. SEQ_ISSUE then goes to IDLE.
- Once started, a sequence completes regardless of the enables. Nothing is interleaved between ESC and its second character.
- Time-code pending flag:
  - Set by tick_i, which also latches time_i.
  - A tick while already pending overwrites the value.
  - Cleared at the ISSUE of its ESC.
  - A tick in that same cycle re-sets the flag with the new value.
- fct_pend (3 bits):
  - +1 on fct_req_i, saturating at 7.
  - −1 at ISSUE of an FCT.
  - Both in the same cycle leave it unchanged.
- fifo_pop_o pulses in the ISSUE cycle of an N-char.
- Credit:
  - +CREDIT_STEP on fct_rx_i.
  - −1 at ISSUE of an N-char.
  - Both in the same cycle give a net +7.
  - If the increment would exceed CREDIT_MAX, set credit_err_o; credit still takes any decrement but not the increment.
  - credit_err_o stays set until reset.
- Reset values: all outputs 0, credit 0, fct_pend 0, time-code flag clear, FSM in IDLE.

## Timing
- Request pending with ready_i=1 in IDLE: valid_o is high on the next cycle.
- valid_o is never high on two consecutive cycles.
- dat_o/lchar_o are stable while valid_o=1.
- After ISSUE, the FSM returns to IDLE. Since the encoder is then busy, ready_i is low and no new selection occurs until the encoder finishes.
- NULL takes two handshakes. ESC and FCT are each issued one cycle after the respective ready_i=1.
- TxReset mid-sequence returns the FSM to IDLE immediately. The pending second character is discarded, and valid_o goes low asynchronously.

## Test plan
- Reset: assert TxReset at an arbitrary point. Required: all outputs 0, credit_o=0, and valid_o low without waiting for a clock.
- en_null_i=1 only, with ready_i modelled as an encoder: the stream is ESC(11), FCT(00), ESC, FCT…, each char a single valid_o pulse.
- en_fct_i=1, three fct_req_i pulses, fifo holding 0x5A with credit=8: three FCTs are issued before 0x5A; fifo_pop_o pulses once, together with 0x5A's valid_o.
- Credit gating:
  - credit=0, FIFO holds 10 bytes, en_null_i=1: only NULLs are sent.
  - One fct_rx_i pulse: exactly 8 data chars are sent, then NULLs resume, and credit_o reads 0.
- Time-code atomicity: tick_i with time_i=0x2C while an FCT is pending. The stream is ESC, then 0x2C with lchar_o=0, then FCT. A second tick before the ESC issues replaces the value.
- Overflow: seven fct_rx_i pulses with no N-chars give credit_o=56; an eighth sets credit_err_o=1 with credit_o=56. fct_rx_i in the same cycle as an N-char issue at credit 10 gives credit_o=17.
